drop_controller: RTL and testbench
==================================

// Module: drop_controller
// PURPOSE
//  Consumer of the gravity timer's moveDown tick and the debounced player buttons. Arbitrates
//  them into one piece-move command at a time towards the board logic (valid/ready + response),
//  and runs lock delay and hard drop. Sends rst_timer back to the gravity timer so the fall
//  interval restarts after a soft drop or a lock. Sits between input/timer logic and board engine.
// PARAMETERS
//  LOCK_CYCLES  5_000_000  clk cycles a grounded piece may stay before lock is requested
//  CW           32         width of lock-delay counter; must hold LOCK_CYCLES
//  HARD_MAX     24         max DOWN steps in one hard drop (board rows); limit reached -> lock
// PORTS
//  clk        in   1  clock
//  rst        in   1  reset, asynchronous, active-low
//  tick_down  in   1  gravity tick from timer, 1-cycle pulse
//  btn_left   in   1  1-cycle pulse: move left
//  btn_right  in   1  1-cycle pulse: move right
//  btn_rot    in   1  1-cycle pulse: rotate
//  btn_soft   in   1  1-cycle pulse: soft drop one row
//  btn_hard   in   1  1-cycle pulse: hard drop
//  cmd_valid  out  1  command offered to board
//  cmd_op     out  2  0 LEFT, 1 RIGHT, 2 ROT, 3 DOWN; stable while cmd_valid && !cmd_ready
//  cmd_ready  in   1  board accepts command this cycle
//  resp_valid in   1  board result for the accepted command, 1-cycle pulse
//  resp_ok    in   1  with resp_valid: 1 move applied, 0 blocked (collision)
//  lock_req   out  1  request board to lock piece; held until lock_ack
//  lock_ack   in   1  board has locked and spawned next piece
//  rst_timer  out  1  1-cycle pulse to restart gravity timer
//  busy       out  1  FSM not in IDLE
// BEHAVIOUR
//  Reset: cmd_valid=0, cmd_op=0, lock_req=0, rst_timer=0, busy=0; pending bits, lock_pending,
//   lock counter, hard-drop step count all 0; FSM=IDLE. Reset mid-command drops everything.
//  Pending capture: each input pulse sets its pending bit in any state (incl. same cycle as
//   issue); re-pulse while set collapses. tick_down and btn_soft share one pend_down bit
//   (soft flag remembered). Bits clear only when their command is issued.
//  States: IDLE, ISSUE, WAIT, LOCK.
//  IDLE: priority pend_hard > pend_down > pend_rot > pend_left > pend_right. Chosen op goes to
//   ISSUE next cycle; its pend bit clears. Hard: pend_hard and pend_down clear, step count=0,
//   op DOWN, hard mode set. Left+right same cycle: left first, right next.
//  ISSUE: cmd_valid=1; on cmd_ready -> WAIT (cmd_valid drops next cycle).
//  WAIT: ignore until resp_valid. Then:
//   DOWN ok, hard mode: step+1; step<HARD_MAX -> ISSUE DOWN again, else -> LOCK.
//   DOWN blocked, hard mode -> LOCK.
//   DOWN ok, normal: lock_pending=0; if soft flag, rst_timer pulse. -> IDLE.
//   DOWN blocked, normal: if !lock_pending set it, load counter=LOCK_CYCLES. -> IDLE.
//   LEFT/RIGHT/ROT ok: lock_pending=0 (piece may fall again). -> IDLE. Blocked: -> IDLE.
//  Lock delay: while lock_pending, counter decrements each cycle in every state except LOCK;
//   reaching 0 in IDLE -> LOCK (before any pending command). At 0 outside IDLE, LOCK entered on
//   next IDLE cycle.
//  LOCK: lock_req=1 until lock_ack; on lock_ack: lock_req=0, rst_timer pulse, lock_pending=0,
//   hard mode cleared, all pending bits cleared (inputs for the old piece discarded) -> IDLE.
//  rst_timer never asserted two consecutive cycles; never asserted in reset.
//  resp_valid outside WAIT and lock_ack outside LOCK ignored.
// TESTING (bench LOCK_CYCLES=4, HARD_MAX=3)
//  tick_down, cmd_ready=1, resp_ok=1 -> cmd_valid/op=3 one cycle, no rst_timer, back IDLE.
//  btn_soft, resp_ok=1 -> op=3, rst_timer 1 cycle after resp_valid; btn_soft+tick same cycle
//   -> exactly one DOWN.
//  btn_left+btn_right+btn_rot same cycle, cmd_ready held 0 three cycles -> op stays 2, then
//   order ROT,LEFT,RIGHT.
//  DOWN blocked -> lock_req after 4 cycles; lock_ack -> rst_timer pulse, pendings cleared.
//  DOWN blocked, then LEFT ok within 4 cycles -> no lock_req.
//  btn_hard, resp_ok=1 always -> 3 DOWNs then lock_req; rst mid-WAIT -> all outputs 0.

Source files
------------

// File: rtl/drop_controller.sv
// Arbitrates gravity ticks and player buttons into one board move at a time,
// and runs lock delay, hard drop and gravity-timer restart.
module drop_controller #(
  parameter int unsigned LOCK_CYCLES = 5_000_000,
  parameter int unsigned CW          = 32,
  parameter int unsigned HARD_MAX    = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_rot,
  input  logic       btn_soft,
  input  logic       btn_hard,
  output logic       cmd_valid,
  output logic [1:0] cmd_op,
  input  logic       cmd_ready,
  input  logic       resp_valid,
  input  logic       resp_ok,
  output logic       lock_req,
  input  logic       lock_ack,
  output logic       rst_timer,
  output logic       busy
);

  localparam int unsigned SW = $clog2(HARD_MAX + 1);

  localparam logic [1:0] OP_LEFT  = 2'd0;
  localparam logic [1:0] OP_RIGHT = 2'd1;
  localparam logic [1:0] OP_ROT   = 2'd2;
  localparam logic [1:0] OP_DOWN  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_LOCK} state_t;

  state_t        state_q;
  logic          pend_left_q, pend_right_q, pend_rot_q, pend_down_q, pend_hard_q, soft_q;
  logic          pend_left_d, pend_right_d, pend_rot_d, pend_down_d, pend_hard_d, soft_d;
  logic          cur_soft_q, hard_q, lock_pending_q;
  logic [CW-1:0] lock_cnt_q;
  logic [SW-1:0] step_q;
  logic [SW-1:0] step_inc_c;
  logic [1:0]    op_q;
  logic          cmd_valid_q, lock_req_q, rst_timer_q, busy_q;

  logic idle_c, lock_due_c, go_c, flush_c;
  logic sel_hard_c, sel_down_c, sel_rot_c, sel_left_c, sel_right_c;

  // IDLE arbitration; an expired lock delay pre-empts every pending move
  always_comb begin
    idle_c      = (state_q == S_IDLE);
    lock_due_c  = lock_pending_q && (lock_cnt_q == '0);
    go_c        = idle_c && !lock_due_c;
    flush_c     = (state_q == S_LOCK) && lock_ack;
    sel_hard_c  = go_c && pend_hard_q;
    sel_down_c  = go_c && !pend_hard_q && pend_down_q;
    sel_rot_c   = go_c && !pend_hard_q && !pend_down_q && pend_rot_q;
    sel_left_c  = go_c && !pend_hard_q && !pend_down_q && !pend_rot_q && pend_left_q;
    sel_right_c = go_c && !pend_hard_q && !pend_down_q && !pend_rot_q && !pend_left_q
                  && pend_right_q;
    step_inc_c  = step_q + SW'(1);
  end

  // Pending bits: a new pulse wins over the issue-clear; a lock flushes everything
  always_comb begin
    pend_hard_d  = flush_c ? 1'b0 : ((pend_hard_q  & ~sel_hard_c) | btn_hard);
    pend_down_d  = flush_c ? 1'b0 : ((pend_down_q  & ~(sel_hard_c | sel_down_c))
                                     | tick_down | btn_soft);
    soft_d       = flush_c ? 1'b0 : ((soft_q       & ~(sel_hard_c | sel_down_c)) | btn_soft);
    pend_rot_d   = flush_c ? 1'b0 : ((pend_rot_q   & ~sel_rot_c)   | btn_rot);
    pend_left_d  = flush_c ? 1'b0 : ((pend_left_q  & ~sel_left_c)  | btn_left);
    pend_right_d = flush_c ? 1'b0 : ((pend_right_q & ~sel_right_c) | btn_right);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      pend_left_q    <= 1'b0;
      pend_right_q   <= 1'b0;
      pend_rot_q     <= 1'b0;
      pend_down_q    <= 1'b0;
      pend_hard_q    <= 1'b0;
      soft_q         <= 1'b0;
      cur_soft_q     <= 1'b0;
      hard_q         <= 1'b0;
      lock_pending_q <= 1'b0;
      lock_cnt_q     <= '0;
      step_q         <= '0;
      op_q           <= OP_LEFT;
      cmd_valid_q    <= 1'b0;
      lock_req_q     <= 1'b0;
      rst_timer_q    <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      pend_left_q  <= pend_left_d;
      pend_right_q <= pend_right_d;
      pend_rot_q   <= pend_rot_d;
      pend_down_q  <= pend_down_d;
      pend_hard_q  <= pend_hard_d;
      soft_q       <= soft_d;
      rst_timer_q  <= 1'b0;

      if (lock_pending_q && (state_q != S_LOCK) && (lock_cnt_q != '0))
        lock_cnt_q <= lock_cnt_q - CW'(1);

      unique case (state_q)
        S_IDLE: begin
          if (lock_due_c) begin
            state_q    <= S_LOCK;
            lock_req_q <= 1'b1;
            busy_q     <= 1'b1;
          end else if (sel_hard_c || sel_down_c || sel_rot_c || sel_left_c || sel_right_c) begin
            state_q     <= S_ISSUE;
            cmd_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            cur_soft_q  <= sel_down_c && soft_q;
            if (sel_hard_c) begin
              hard_q <= 1'b1;
              step_q <= '0;
            end
            if (sel_hard_c || sel_down_c) op_q <= OP_DOWN;
            else if (sel_rot_c)           op_q <= OP_ROT;
            else if (sel_left_c)          op_q <= OP_LEFT;
            else                          op_q <= OP_RIGHT;
          end
        end
        S_ISSUE: begin
          if (cmd_ready) begin
            state_q     <= S_WAIT;
            cmd_valid_q <= 1'b0;
          end
        end
        S_WAIT: begin
          if (resp_valid) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            if (op_q == OP_DOWN && hard_q) begin
              // Hard drop keeps stepping until blocked or the row limit is hit
              if (resp_ok) step_q <= step_inc_c;
              if (resp_ok && (step_inc_c < SW'(HARD_MAX))) begin
                state_q     <= S_ISSUE;
                cmd_valid_q <= 1'b1;
                busy_q      <= 1'b1;
              end else begin
                state_q    <= S_LOCK;
                lock_req_q <= 1'b1;
                busy_q     <= 1'b1;
              end
            end else if (op_q == OP_DOWN) begin
              if (resp_ok) begin
                lock_pending_q <= 1'b0;
                rst_timer_q    <= cur_soft_q;
              end else if (!lock_pending_q) begin
                lock_pending_q <= 1'b1;
                lock_cnt_q     <= CW'(LOCK_CYCLES);
              end
            end else if (resp_ok) begin
              lock_pending_q <= 1'b0;
            end
          end
        end
        S_LOCK: begin
          if (lock_ack) begin
            state_q        <= S_IDLE;
            busy_q         <= 1'b0;
            lock_req_q     <= 1'b0;
            rst_timer_q    <= 1'b1;
            lock_pending_q <= 1'b0;
            hard_q         <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_op    = op_q;
  assign lock_req  = lock_req_q;
  assign rst_timer = rst_timer_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_drop_controller.sv
// Self-checking bench for drop_controller: issued ops are scoreboarded against
// the order expected from the buttons pressed; lock and timer handshakes checked inline.
module tb_drop_controller;

  localparam logic [1:0] OP_LEFT  = 2'd0;
  localparam logic [1:0] OP_RIGHT = 2'd1;
  localparam logic [1:0] OP_ROT   = 2'd2;
  localparam logic [1:0] OP_DOWN  = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic       btn_rot = 1'b0, btn_soft = 1'b0, btn_hard = 1'b0;
  logic       cmd_valid, lock_req, rst_timer, busy;
  logic [1:0] cmd_op;
  logic       cmd_ready = 1'b0, resp_valid = 1'b0, resp_ok = 1'b0, lock_ack = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  logic [1:0] sb[$];

  drop_controller #(.LOCK_CYCLES(4), .CW(8), .HARD_MAX(3)) dut (
    .clk(clk), .rst(rst), .tick_down(tick_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_rot(btn_rot), .btn_soft(btn_soft), .btn_hard(btn_hard),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
    .resp_valid(resp_valid), .resp_ok(resp_ok), .lock_req(lock_req),
    .lock_ack(lock_ack), .rst_timer(rst_timer), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // b: {hard, soft, rot, right, left, tick}
  task automatic pulse(input logic [5:0] b);
    {btn_hard, btn_soft, btn_rot, btn_right, btn_left, tick_down} = b;
    step();
    {btn_hard, btn_soft, btn_rot, btn_right, btn_left, tick_down} = 6'b0;
  endtask

  // Waits for an offered command, holds ready low for 'hold' cycles, then accepts.
  task automatic get_cmd(input int hold, output logic [1:0] op, output bit stable);
    int n = 0;
    stable = 1'b1;
    while (cmd_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (cmd_valid !== 1'b1) begin
      op = 2'bxx;
      stable = 1'b0;
    end else begin
      op = cmd_op;
      for (int i = 0; i < hold; i++) begin
        step();
        if (cmd_valid !== 1'b1 || cmd_op !== op) stable = 1'b0;
      end
      cmd_ready = 1'b1;
      step();
      cmd_ready = 1'b0;
      if (cmd_valid !== 1'b0) stable = 1'b0;
    end
  endtask

  task automatic respond(input logic ok);
    resp_valid = 1'b1;
    resp_ok = ok;
    step();
    resp_valid = 1'b0;
    resp_ok = 1'b0;
  endtask

  task automatic watch(input int n, output int nv, output int nl, output int nt);
    nv = 0; nl = 0; nt = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (cmd_valid === 1'b1) nv++;
      if (lock_req === 1'b1) nl++;
      if (rst_timer === 1'b1) nt++;
    end
  endtask

  task automatic test_reset();
    logic [5:0] obs;
    obs = {cmd_valid, cmd_op, lock_req, rst_timer, busy};
    n_cmp++;
    if (obs !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want 000000", obs);
    end
  endtask

  task automatic test_tick();
    logic [1:0] op, exp;
    bit st;
    sb.push_back(OP_DOWN);
    pulse(6'b000001);
    get_cmd(0, op, st);
    exp = sb.pop_front();
    n_cmp++;
    if (op !== exp) begin n_bad++; $display("FAIL tick_op: got %0d want %0d", op, exp); end
    n_cmp++;
    if (st !== 1'b1) begin n_bad++; $display("FAIL tick_valid_one_cycle: got %0d want 1", st); end
    respond(1'b1);
    n_cmp++;
    if (rst_timer !== 1'b0) begin n_bad++; $display("FAIL tick_no_rst_timer: got %b want 0", rst_timer); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL tick_back_idle: busy %b want 0", busy); end
  endtask

  task automatic test_soft();
    logic [1:0] op, exp;
    bit st;
    int nv, nl, nt;
    sb.push_back(OP_DOWN);
    pulse(6'b010000);
    get_cmd(0, op, st);
    exp = sb.pop_front();
    n_cmp++;
    if (op !== exp) begin n_bad++; $display("FAIL soft_op: got %0d want %0d", op, exp); end
    respond(1'b1);
    n_cmp++;
    if (rst_timer !== 1'b1) begin n_bad++; $display("FAIL soft_rst_timer: got %b want 1", rst_timer); end
    step();
    n_cmp++;
    if (rst_timer !== 1'b0) begin n_bad++; $display("FAIL soft_rst_timer_width: got %b want 0", rst_timer); end
    // soft and tick together collapse into one DOWN
    sb.push_back(OP_DOWN);
    pulse(6'b010001);
    get_cmd(0, op, st);
    exp = sb.pop_front();
    n_cmp++;
    if (op !== exp) begin n_bad++; $display("FAIL soft_tick_op: got %0d want %0d", op, exp); end
    respond(1'b1);
    n_cmp++;
    if (rst_timer !== 1'b1) begin n_bad++; $display("FAIL soft_tick_rst_timer: got %b want 1", rst_timer); end
    watch(8, nv, nl, nt);
    n_cmp++;
    if (nv !== 0) begin n_bad++; $display("FAIL soft_tick_single_cmd: extra valid cycles %0d want 0", nv); end
  endtask

  task automatic test_multi();
    logic [1:0] op, exp;
    bit st;
    sb.push_back(OP_ROT);
    sb.push_back(OP_LEFT);
    sb.push_back(OP_RIGHT);
    pulse(6'b001110);
    get_cmd(3, op, st);
    n_cmp++;
    if (st !== 1'b1) begin n_bad++; $display("FAIL multi_hold_stable: got %0d want 1", st); end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) get_cmd(0, op, st);
      exp = sb.pop_front();
      n_cmp++;
      if (op !== exp) begin n_bad++; $display("FAIL multi_order[%0d]: got %0d want %0d", i, op, exp); end
      respond(1'b1);
    end
  endtask

  task automatic test_lock();
    logic [1:0] op, exp;
    bit st;
    int n, nv, nl, nt;
    sb.push_back(OP_DOWN);
    pulse(6'b000001);
    get_cmd(0, op, st);
    exp = sb.pop_front();
    n_cmp++;
    if (op !== exp) begin n_bad++; $display("FAIL lock_down_op: got %0d want %0d", op, exp); end
    respond(1'b0);
    n = 0;
    while (lock_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    n_cmp++;
    if (n < 4 || n > 5) begin n_bad++; $display("FAIL lock_delay: lock_req after %0d cycles want 4..5", n); end
    pulse(6'b000010);
    watch(3, nv, nl, nt);
    n_cmp++;
    if (nl !== 3 || nv !== 0) begin
      n_bad++;
      $display("FAIL lock_hold: lock_req cycles %0d want 3, valid cycles %0d want 0", nl, nv);
    end
    lock_ack = 1'b1;
    step();
    lock_ack = 1'b0;
    n_cmp++;
    if ({lock_req, rst_timer} !== 2'b01) begin
      n_bad++;
      $display("FAIL lock_ack: lock_req,rst_timer %b want 01", {lock_req, rst_timer});
    end
    watch(8, nv, nl, nt);
    n_cmp++;
    if (nv !== 0 || nt !== 0) begin
      n_bad++;
      $display("FAIL lock_flush: valid cycles %0d rst_timer cycles %0d want 0 0", nv, nt);
    end
  endtask

  task automatic test_unlock();
    logic [1:0] op, exp;
    bit st;
    int nv, nl, nt;
    sb.push_back(OP_DOWN);
    sb.push_back(OP_LEFT);
    pulse(6'b000001);
    get_cmd(0, op, st);
    exp = sb.pop_front();
    n_cmp++;
    if (op !== exp) begin n_bad++; $display("FAIL unlock_down_op: got %0d want %0d", op, exp); end
    respond(1'b0);
    pulse(6'b000010);
    get_cmd(0, op, st);
    exp = sb.pop_front();
    n_cmp++;
    if (op !== exp) begin n_bad++; $display("FAIL unlock_left_op: got %0d want %0d", op, exp); end
    respond(1'b1);
    watch(12, nv, nl, nt);
    n_cmp++;
    if (nl !== 0) begin n_bad++; $display("FAIL unlock_no_lock: lock_req cycles %0d want 0", nl); end
  endtask

  task automatic test_hard();
    logic [1:0] op, exp;
    bit st;
    int nv, nl, nt;
    for (int i = 0; i < 3; i++) sb.push_back(OP_DOWN);
    pulse(6'b100000);
    for (int i = 0; i < 3; i++) begin
      get_cmd(0, op, st);
      exp = sb.pop_front();
      n_cmp++;
      if (op !== exp) begin n_bad++; $display("FAIL hard_op[%0d]: got %0d want %0d", i, op, exp); end
      respond(1'b1);
    end
    n_cmp++;
    if (lock_req !== 1'b1) begin n_bad++; $display("FAIL hard_lock_req: got %b want 1", lock_req); end
    watch(3, nv, nl, nt);
    n_cmp++;
    if (nv !== 0) begin n_bad++; $display("FAIL hard_step_limit: extra valid cycles %0d want 0", nv); end
    lock_ack = 1'b1;
    step();
    lock_ack = 1'b0;
    n_cmp++;
    if (rst_timer !== 1'b1) begin n_bad++; $display("FAIL hard_ack_rst_timer: got %b want 1", rst_timer); end
  endtask

  task automatic test_reset_mid_wait();
    logic [1:0] op, exp;
    bit st;
    int nv, nl, nt;
    logic [5:0] obs;
    sb.push_back(OP_DOWN);
    pulse(6'b000001);
    get_cmd(0, op, st);
    exp = sb.pop_front();
    n_cmp++;
    if (op !== exp) begin n_bad++; $display("FAIL rstwait_op: got %0d want %0d", op, exp); end
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL rstwait_busy: got %b want 1", busy); end
    pulse(6'b001000);
    rst = 1'b0;
    #1;
    obs = {cmd_valid, cmd_op, lock_req, rst_timer, busy};
    n_cmp++;
    if (obs !== 6'b0) begin n_bad++; $display("FAIL rstwait_outputs: got %b want 000000", obs); end
    step();
    rst = 1'b1;
    watch(8, nv, nl, nt);
    n_cmp++;
    if (nv !== 0 || nl !== 0 || nt !== 0) begin
      n_bad++;
      $display("FAIL rstwait_dropped: valid %0d lock %0d timer %0d want 0 0 0", nv, nl, nt);
    end
  endtask

  initial begin
    step();
    step();
    test_reset();
    rst = 1'b1;
    step();
    test_tick();
    test_soft();
    test_multi();
    test_lock();
    test_unlock();
    test_hard();
    test_reset_mid_wait();
    n_cmp++;
    if (sb.size() !== 0) begin n_bad++; $display("FAIL scoreboard_drain: %0d left want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
